int_controller: RTL

INT_CONTROLLER -- requirements
Module: int_controller

---
 rtl/int_controller.sv | 121 ++++++++++++
 1 files changed

// File: rtl/int_controller.sv
// Vectored interrupt controller: edge-detected pending latches, mask register,
// lowest-index priority, and a REQ/SERVICE handshake with the CPU.
module int_controller #(
    parameter int NSRC  = 8,
    parameter int VEC_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              global_int_en,
    input  logic [NSRC-1:0]   irq_src,
    output logic              int_req,
    output logic [VEC_W-1:0]  int_vec,
    input  logic              int_ack,
    input  logic              int_eoi,
    output logic              in_service,
    input  logic              reg_we,
    input  logic [1:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NSRC-1:0]   prev;
    logic [NSRC-1:0]   mask;
    logic [NSRC-1:0]   pending;
    logic [NSRC-1:0]   edges;
    logic [NSRC-1:0]   active;
    logic [NSRC-1:0]   w1c;
    logic [NSRC-1:0]   ack_clr;
    logic [VEC_W-1:0]  vec_sel;
    logic [VEC_W-1:0]  vec_nxt;
    logic              sel_found;
    logic              cur_active;
    logic              mask_we;
    logic              unused_wdata_hi;

    assign edges      = irq_src & ~prev;
    assign active     = pending & mask;
    assign cur_active = pending[int_vec] & mask[int_vec];
    assign mask_we    = reg_we && (reg_addr == 2'd0);
    assign w1c        = (reg_we && (reg_addr == 2'd1)) ? reg_wdata[NSRC-1:0] : '0;
    assign int_req    = (state == REQ);
    assign in_service = (state == SERVICE);
    assign unused_wdata_hi = ^reg_wdata[31:NSRC];

    // Lowest-index enabled pending source wins
    always_comb begin
        vec_sel   = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (!sel_found && active[i]) begin
                vec_sel   = VEC_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    // Next-state, vector latch and acknowledge clear
    always_comb begin
        state_nxt = state;
        vec_nxt   = int_vec;
        ack_clr   = '0;
        case (state)
            IDLE: begin
                if (global_int_en && sel_found) begin
                    state_nxt = REQ;
                    vec_nxt   = vec_sel;
                end
            end
            REQ: begin
                // ack beats a simultaneous withdrawal
                if (int_ack) begin
                    state_nxt = SERVICE;
                    ack_clr   = NSRC'(1) << int_vec;
                end else if (!global_int_en || !cur_active) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (int_eoi) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, edge history, mask and pending registers (new edge wins over clear)
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            int_vec <= '0;
            prev    <= '0;
            mask    <= '0;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            int_vec <= vec_nxt;
            prev    <= irq_src;
            if (mask_we) mask <= reg_wdata[NSRC-1:0];
            pending <= (pending & ~(w1c | ack_clr)) | edges;
        end
    end

    // Combinational register read mux
    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            2'd0: reg_rdata[NSRC-1:0] = mask;
            2'd1: reg_rdata[NSRC-1:0] = pending;
            2'd2: begin
                reg_rdata[31]        = in_service;
                reg_rdata[30]        = int_req;
                reg_rdata[VEC_W-1:0] = int_vec;
            end
            default: reg_rdata[NSRC-1:0] = irq_src;
        endcase
    end

endmodule
